// File: rtl/prf_scoreboard.sv
// Physical register file with a per-entry ready scoreboard, write-back conflict flag and busy count.
// Optional same-cycle write-to-read forwarding is enabled by defining PRF_BYPASS_EN.
module prf_scoreboard #(
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 96,
    parameter int IDX_W     = 7,
    parameter int NUM_RD    = 12,
    parameter int NUM_WR    = 6,
    parameter int NUM_ALLOC = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_RD*IDX_W-1:0]     rd_idx,
    output logic [NUM_RD*DATA_W-1:0]    rd_value,
    output logic [NUM_RD-1:0]           rd_ready,
    input  logic [NUM_WR-1:0]           wr_en,
    input  logic [NUM_WR*IDX_W-1:0]     wr_idx,
    input  logic [NUM_WR*DATA_W-1:0]    wr_value,
    input  logic [NUM_ALLOC-1:0]        alloc_en,
    input  logic [NUM_ALLOC*IDX_W-1:0]  alloc_idx,
    output logic                        wr_conflict,
    output logic [IDX_W:0]              busy_count
);

    localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

    logic [DATA_W-1:0] data     [DEPTH];
    logic [DATA_W-1:0] data_nxt [DEPTH];
    logic [DEPTH-1:0]  ready;
    logic [DEPTH-1:0]  ready_nxt;
    logic              conflict_nxt;
    logic [IDX_W:0]    busy_nxt;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} < DEPTH_L;
    endfunction

    // Writes are applied in port order so the highest-numbered port wins;
    // allocations are applied last so they override a same-cycle write's ready.
    always_comb begin
        data_nxt     = data;
        ready_nxt    = ready;
        conflict_nxt = 1'b0;
        busy_nxt     = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k] && in_range(wr_idx[k*IDX_W +: IDX_W])) begin
                data_nxt[wr_idx[k*IDX_W +: IDX_W]]  = wr_value[k*DATA_W +: DATA_W];
                ready_nxt[wr_idx[k*IDX_W +: IDX_W]] = 1'b1;
            end
        end
        for (int k = 0; k < NUM_WR; k++) begin
            for (int j = k + 1; j < NUM_WR; j++) begin
                if (wr_en[k] && wr_en[j] && in_range(wr_idx[k*IDX_W +: IDX_W]) &&
                    (wr_idx[k*IDX_W +: IDX_W] == wr_idx[j*IDX_W +: IDX_W]))
                    conflict_nxt = 1'b1;
            end
        end
        for (int a = 0; a < NUM_ALLOC; a++) begin
            if (alloc_en[a] && in_range(alloc_idx[a*IDX_W +: IDX_W]))
                ready_nxt[alloc_idx[a*IDX_W +: IDX_W]] = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            busy_nxt = busy_nxt + {{IDX_W{1'b0}}, ~ready_nxt[i]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= '0;
            end
            ready       <= '1;
            wr_conflict <= 1'b0;
            busy_count  <= '0;
        end else begin
            data        <= data_nxt;
            ready       <= ready_nxt;
            wr_conflict <= conflict_nxt;
            busy_count  <= busy_nxt;
        end
    end

    always_comb begin
        rd_value = '0;
        rd_ready = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            if (in_range(rd_idx[r*IDX_W +: IDX_W])) begin
                rd_value[r*DATA_W +: DATA_W] = data[rd_idx[r*IDX_W +: IDX_W]];
                rd_ready[r]                  = ready[rd_idx[r*IDX_W +: IDX_W]];
            end
`ifdef PRF_BYPASS_EN
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] && in_range(wr_idx[k*IDX_W +: IDX_W]) &&
                    (wr_idx[k*IDX_W +: IDX_W] == rd_idx[r*IDX_W +: IDX_W])) begin
                    rd_value[r*DATA_W +: DATA_W] = wr_value[k*DATA_W +: DATA_W];
                    rd_ready[r]                  = 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_prf_scoreboard.sv
// Directed bench for prf_scoreboard: vector table of single-cycle write/alloc operations
// plus hand-written sequences for reset, conflict, forwarding and mid-run reset.
module tb_prf_scoreboard;

    localparam int DATA_W    = 64;
    localparam int DEPTH     = 96;
    localparam int IDX_W     = 7;
    localparam int NUM_RD    = 12;
    localparam int NUM_WR    = 6;
    localparam int NUM_ALLOC = 2;

    logic                        clock = 1'b0;
    logic                        reset;
    logic [NUM_RD*IDX_W-1:0]     rd_idx;
    logic [NUM_RD*DATA_W-1:0]    rd_value;
    logic [NUM_RD-1:0]           rd_ready;
    logic [NUM_WR-1:0]           wr_en;
    logic [NUM_WR*IDX_W-1:0]     wr_idx;
    logic [NUM_WR*DATA_W-1:0]    wr_value;
    logic [NUM_ALLOC-1:0]        alloc_en;
    logic [NUM_ALLOC*IDX_W-1:0]  alloc_idx;
    logic                        wr_conflict;
    logic [IDX_W:0]              busy_count;

    int n_tests = 0;
    int n_fail  = 0;

    prf_scoreboard #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W),
        .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .NUM_ALLOC(NUM_ALLOC)
    ) dut (
        .clock(clock), .reset(reset),
        .rd_idx(rd_idx), .rd_value(rd_value), .rd_ready(rd_ready),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_value(wr_value),
        .alloc_en(alloc_en), .alloc_idx(alloc_idx),
        .wr_conflict(wr_conflict), .busy_count(busy_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          wp;
        logic        we;
        logic [6:0]  wi;
        logic [63:0] wv;
        int          ap;
        logic        ae;
        logic [6:0]  ai;
        logic [6:0]  ri;
        logic [63:0] exp_val;
        logic        exp_rdy;
        int          exp_busy;
        logic        exp_conf;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        wr_en     = '0;
        wr_idx    = '0;
        wr_value  = '0;
        alloc_en  = '0;
        alloc_idx = '0;
        rd_idx    = '0;
    endtask

    task automatic drive_wr(input int p, input logic [6:0] idx, input logic [63:0] val);
        wr_en[p]                     = 1'b1;
        wr_idx[p*IDX_W +: IDX_W]     = idx;
        wr_value[p*DATA_W +: DATA_W] = val;
    endtask

    task automatic drive_alloc(input int p, input logic [6:0] idx);
        alloc_en[p]                 = 1'b1;
        alloc_idx[p*IDX_W +: IDX_W] = idx;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] rv(input int r);
        return rd_value[r*DATA_W +: DATA_W];
    endfunction

    initial begin
        //          wp we wi   wv            ap ae ai   ri   exp_val       rdy busy conf
        vecs[0] = '{0, 0, 0,   64'h0,        0, 1, 5,   5,   64'h0,        0,  1,   0};
        vecs[1] = '{3, 1, 5,   64'hDEADBEEF, 0, 0, 0,   5,   64'hDEADBEEF, 1,  0,   0};
        vecs[2] = '{0, 1, 7,   64'h55,       1, 1, 7,   7,   64'h55,       0,  1,   0};
        vecs[3] = '{1, 1, 30,  64'h1234,     1, 1, 31,  30,  64'h1234,     1,  2,   0};
        vecs[4] = '{5, 1, 100, 64'hFF,       0, 1, 127, 100, 64'h0,        0,  2,   0};
        vecs[5] = '{2, 1, 31,  64'h77,       0, 0, 0,   31,  64'h77,       1,  1,   0};
        vecs[6] = '{0, 1, 95,  64'h9,        0, 1, 95,  95,  64'h9,        0,  2,   0};
        vecs[7] = '{0, 1, 96,  64'h3,        0, 0, 0,   96,  64'h0,        0,  2,   0};

        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state: sweep all entries across all read ports.
        chk("reset_busy", 64'(busy_count), 64'd0);
        chk("reset_conf", 64'(wr_conflict), 64'd0);
        for (int g = 0; g < DEPTH / NUM_RD; g++) begin
            for (int r = 0; r < NUM_RD; r++) rd_idx[r*IDX_W +: IDX_W] = 7'(g*NUM_RD + r);
            #1;
            for (int r = 0; r < NUM_RD; r++) begin
                chk($sformatf("reset_val_%0d", g*NUM_RD + r), rv(r), 64'h0);
                chk($sformatf("reset_rdy_%0d", g*NUM_RD + r), 64'(rd_ready[r]), 64'd1);
            end
        end
        clear_inputs();

        for (int v = 0; v < 8; v++) begin
            clear_inputs();
            if (vecs[v].we) drive_wr(vecs[v].wp, vecs[v].wi, vecs[v].wv);
            if (vecs[v].ae) drive_alloc(vecs[v].ap, vecs[v].ai);
            next_cycle();
            clear_inputs();
            rd_idx[0 +: IDX_W] = vecs[v].ri;
            rd_idx[11*IDX_W +: IDX_W] = vecs[v].ri;
            #1;
            chk($sformatf("v%0d_val", v), rv(0), vecs[v].exp_val);
            chk($sformatf("v%0d_val_p11", v), rv(11), vecs[v].exp_val);
            chk($sformatf("v%0d_rdy", v), 64'(rd_ready[0]), 64'(vecs[v].exp_rdy));
            chk($sformatf("v%0d_busy", v), 64'(busy_count), 64'(vecs[v].exp_busy));
            chk($sformatf("v%0d_conf", v), 64'(wr_conflict), 64'(vecs[v].exp_conf));
        end

        // Same-index writes on ports 0 and 4: port 4 wins, conflict for one cycle.
        clear_inputs();
        drive_wr(0, 10, 64'h1);
        drive_wr(4, 10, 64'h2);
        next_cycle();
        clear_inputs();
        rd_idx[0 +: IDX_W] = 10;
        #1;
        chk("conf_val", rv(0), 64'h2);
        chk("conf_flag", 64'(wr_conflict), 64'd1);
        chk("conf_busy", 64'(busy_count), 64'd2);
        next_cycle();
        chk("conf_clear", 64'(wr_conflict), 64'd0);

        // Same-cycle read of a write-back target.
        clear_inputs();
        drive_wr(2, 20, 64'hABC);
        drive_alloc(0, 21);
        drive_wr(1, 21, 64'h11);
        drive_wr(3, 21, 64'h33);
        rd_idx[0 +: IDX_W] = 20;
        rd_idx[1*IDX_W +: IDX_W] = 21;
        #1;
`ifdef PRF_BYPASS_EN
        chk("byp_same_val", rv(0), 64'hABC);
        chk("byp_same_rdy", 64'(rd_ready[0]), 64'd1);
        chk("byp_prio_val", rv(1), 64'h33);
        chk("byp_prio_rdy", 64'(rd_ready[1]), 64'd1);
`else
        chk("byp_same_val", rv(0), 64'h0);
        chk("byp_same_rdy", 64'(rd_ready[0]), 64'd1);
        chk("byp_prio_val", rv(1), 64'h0);
        chk("byp_prio_rdy", 64'(rd_ready[1]), 64'd1);
`endif
        next_cycle();
        clear_inputs();
        rd_idx[0 +: IDX_W] = 20;
        rd_idx[1*IDX_W +: IDX_W] = 21;
        #1;
        chk("byp_next_val", rv(0), 64'hABC);
        chk("byp_next_rdy", 64'(rd_ready[0]), 64'd1);
        chk("alloc_win_val", rv(1), 64'h33);
        chk("alloc_win_rdy", 64'(rd_ready[1]), 64'd0);
        chk("byp_busy", 64'(busy_count), 64'd3);
        chk("byp_conf", 64'(wr_conflict), 64'd1);

        // Reset during active writes and allocations overrides them.
        clear_inputs();
        drive_wr(0, 40, 64'h5A5A);
        drive_wr(5, 40, 64'hA5A5);
        drive_alloc(0, 41);
        drive_alloc(1, 42);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        clear_inputs();
        rd_idx[0 +: IDX_W]       = 40;
        rd_idx[1*IDX_W +: IDX_W] = 41;
        rd_idx[2*IDX_W +: IDX_W] = 5;
        rd_idx[3*IDX_W +: IDX_W] = 7;
        rd_idx[4*IDX_W +: IDX_W] = 95;
        #1;
        chk("rst_busy", 64'(busy_count), 64'd0);
        chk("rst_conf", 64'(wr_conflict), 64'd0);
        for (int r = 0; r < 5; r++) begin
            chk($sformatf("rst_val_p%0d", r), rv(r), 64'h0);
            chk($sformatf("rst_rdy_p%0d", r), 64'(rd_ready[r]), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/prf_scoreboard.md
# prf_scoreboard

Parametrised physical register file with per-entry ready scoreboard for the out-of-order core. It replaces the fixed 96x64, 12-read/6-write register file with configurable width, depth and port counts. It tracks a ready bit per physical register: cleared when dispatch allocates a destination and set when a functional unit writes back. Reservation stations read operand values and ready status from it; ALU/MUL/MEM write-back ports write into it.

## Interface
- DATA_W, 64, register data width
- DEPTH, 96, number of physical registers
- IDX_W, 7, index width; requires 2**IDX_W >= DEPTH
- NUM_RD, 12, read ports
- NUM_WR, 6, write-back ports
- NUM_ALLOC, 2, dispatch allocation ports

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- rd_idx  in  NUM_RD*IDX_W  read indices; port k at [k*IDX_W +: IDX_W]
- rd_value  out  NUM_RD*DATA_W  read data per port
- rd_ready  out  NUM_RD  ready bit of the indexed register
- wr_en  in  NUM_WR  write-back enables
- wr_idx  in  NUM_WR*IDX_W  write-back indices
- wr_value  in  NUM_WR*DATA_W  write-back data
- alloc_en  in  NUM_ALLOC  destination allocation enables
- alloc_idx  in  NUM_ALLOC*IDX_W  allocated physical register indices
- wr_conflict  out  1  registered flag: previous cycle had two enabled writes to one index
- busy_count  out  IDX_W+1  registered count of entries with ready=0

## Operation
- State: data[DEPTH], ready[DEPTH], wr_conflict, busy_count.
- Reset edge: all data = 0, all ready = 1, wr_conflict = 0, busy_count = 0.
- Write: each enabled write port with index < DEPTH loads data and sets ready=1 at the next edge.
- Multiple writes to the same index in one cycle: the highest-numbered port wins; wr_conflict = 1 for exactly the following cycle.
- Allocation: each enabled alloc port with index < DEPTH clears ready at the next edge.
- Alloc and write to the same index in the same cycle: data is written; ready ends at 0 (allocation wins).
- Out-of-range indices (>= DEPTH): writes and allocations are ignored; reads return value 0 and ready 0.
- Read: combinational from current state (or bypassed, see Configuration).
- busy_count: number of ready=0 entries after the update, recomputed each cycle; range 0..DEPTH.
- Reset asserted mid-operation overrides all writes and allocations in that cycle.

## Timing
- Write/alloc latency: one edge; state is visible on reads in the cycle after the edge (without bypass).
- Read latency: zero cycles, combinational from rd_idx.
- wr_conflict and busy_count: registered; they reflect the edge just taken.
- There is no handshake; every port accepts every cycle.

## Configuration
- PRF_BYPASS_EN defined: a read whose index matches an enabled in-range write port in the same cycle returns that write's wr_value and rd_ready=1. The highest-numbered matching port wins. A same-cycle allocation to the read index does not affect rd_ready until the edge.
- PRF_BYPASS_EN undefined: reads return stored state only; same-cycle writes are visible one cycle later.

## Test plan
- Reset, then read all indices 0..95 -> value 0, ready 1; busy_count 0; wr_conflict 0.
- alloc_en[0] idx 5 in cycle 1 -> cycle 2 rd_ready(5)=0, busy_count=1; wr port 3 writes idx 5 = 0xDEADBEEF in cycle 2 -> cycle 3 value 0xDEADBEEF, ready 1, busy_count 0.
- Ports 0 and 4 write idx 10 with 0x1 and 0x2 -> next cycle value 0x2, wr_conflict=1 for one cycle only.
- Same cycle: alloc idx 7 and write idx 7 = 0x55 -> next cycle value 0x55, ready 0, busy_count 1.
- With PRF_BYPASS_EN: write idx 20 = 0xABC while reading idx 20 -> same cycle rd_value 0xABC, rd_ready 1. Without the macro -> old value that cycle, 0xABC the next cycle.
- Write idx 100 and allocate idx 127 with DEPTH=96 -> no state change; reading idx 100 -> value 0, ready 0. Asserting reset during active writes -> all entries 0 and ready after the edge.
